// File: rtl/bip_control_fsm.sv
// bip_control_fsm: BIP control unit; fetch/execute sequencer driving accumulator, ALU and data-RAM strobes.
module bip_control_fsm #(
  parameter int PC_W = 11,
  parameter int OPR_W = 11,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [OPR_W+4:0]   Instruction,
  input  logic               InstrValid,
  input  logic               AccZero,
  output logic               InstrReq,
  output logic [PC_W-1:0]    PC,
  output logic [OPR_W-1:0]   Operand,
  output logic [1:0]         SelA,
  output logic               SelB,
  output logic               WrAcc,
  output logic               Op,
  output logic               WrRam,
  output logic               RdRam,
  output logic               Halted
);
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;
  localparam logic [4:0] HLT = 5'd0, STO = 5'd1, LD = 5'd2, LDI = 5'd3, ADD = 5'd4, ADDI = 5'd5;
  localparam logic [4:0] SUB = 5'd6, SUBI = 5'd7, JMP = 5'd8, BEQ = 5'd9, BNE = 5'd10;
  state_t r_state, w_next;
  logic [4:0] r_opc;
  logic [OPR_W-1:0] r_operand;
  logic [PC_W-1:0] r_pc, w_pc_next, w_pc_inc, w_target;
  if (OPR_W >= PC_W) begin : g_trunc
    assign w_target = r_operand[PC_W-1:0];
  end else begin : g_ext
    assign w_target = {{(PC_W-OPR_W){1'b0}}, r_operand};
  end
  assign w_pc_inc = r_pc + PC_W'(1);
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_pc <= RESET_PC;
      r_operand <= '0;
      r_opc <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH && InstrValid) begin
        r_opc <= Instruction[OPR_W+4:OPR_W];
        r_operand <= Instruction[OPR_W-1:0];
      end
      if (r_state == S_EXEC) r_pc <= w_pc_next;
    end
  end
  always_comb begin
    SelA = 2'd0;
    SelB = 1'b0;
    WrAcc = 1'b0;
    Op = 1'b0;
    WrRam = 1'b0;
    RdRam = 1'b0;
    w_pc_next = w_pc_inc;
    w_next = r_state;
    case (r_state)
      S_FETCH: w_next = InstrValid ? S_EXEC : S_FETCH;
      S_EXEC: begin
        w_next = S_FETCH;
        case (r_opc)
          HLT: begin
            w_next = S_HALT;
            w_pc_next = r_pc;
          end
          STO: WrRam = 1'b1;
          LD: begin
            RdRam = 1'b1;
            WrAcc = 1'b1;
          end
          LDI: begin
            SelA = 2'd1;
            WrAcc = 1'b1;
          end
          ADD, SUB: begin
            RdRam = 1'b1;
            SelA = 2'd2;
            Op = r_opc == SUB;
            WrAcc = 1'b1;
          end
          ADDI, SUBI: begin
            SelB = 1'b1;
            SelA = 2'd2;
            Op = r_opc == SUBI;
            WrAcc = 1'b1;
          end
          JMP: w_pc_next = w_target;
          BEQ: w_pc_next = AccZero ? w_target : w_pc_inc;
          BNE: w_pc_next = AccZero ? w_pc_inc : w_target;
          default: w_pc_next = w_pc_inc;
        endcase
      end
      S_HALT: w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
  end
  assign InstrReq = r_state == S_FETCH;
  assign Halted = r_state == S_HALT;
  assign PC = r_pc;
  assign Operand = r_operand;
endmodule

// File: tb/tb_bip_control_fsm.sv
// tb_bip_control_fsm: directed scoreboard bench for bip_control_fsm (default widths and PC_W=4).
module tb_bip_control_fsm;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic rst0, rst1, valid, az, sel;
  logic [15:0] instr;
  logic req0, selb0, wracc0, op0, wrram0, rdram0, halt0;
  logic req1, selb1, wracc1, op1, wrram1, rdram1, halt1;
  logic [1:0] sela0, sela1;
  logic [10:0] pc0, opr0, opr1;
  logic [3:0] pc1;
  logic [6:0] obs_s;
  logic [10:0] obs_pc, obs_opr;
  logic obs_req, obs_halt;
  int n_run = 0, n_fail = 0;
  typedef struct packed {logic [6:0] s; logic [10:0] opr; logic [10:0] pc;} exp_t;
  exp_t q[$];

  bip_control_fsm d0 (
    .clock(clock), .reset(rst0), .Instruction(instr), .InstrValid(valid), .AccZero(az),
    .InstrReq(req0), .PC(pc0), .Operand(opr0), .SelA(sela0), .SelB(selb0), .WrAcc(wracc0),
    .Op(op0), .WrRam(wrram0), .RdRam(rdram0), .Halted(halt0)
  );
  bip_control_fsm #(.PC_W(4)) d1 (
    .clock(clock), .reset(rst1), .Instruction(instr), .InstrValid(valid), .AccZero(az),
    .InstrReq(req1), .PC(pc1), .Operand(opr1), .SelA(sela1), .SelB(selb1), .WrAcc(wracc1),
    .Op(op1), .WrRam(wrram1), .RdRam(rdram1), .Halted(halt1)
  );

  always_comb begin
    obs_s = sel ? {sela1, selb1, wracc1, op1, wrram1, rdram1} : {sela0, selb0, wracc0, op0, wrram0, rdram0};
    obs_pc = sel ? {7'b0, pc1} : pc0;
    obs_opr = sel ? opr1 : opr0;
    obs_req = sel ? req1 : req0;
    obs_halt = sel ? halt1 : halt0;
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_run++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // s = {SelA[1:0], SelB, WrAcc, Op, WrRam, RdRam}
  task automatic do_instr(input logic [4:0] opc, input logic [10:0] opr, input logic a,
                          input logic [6:0] s, input logic [10:0] pcn);
    exp_t e;
    chk("fetch_req", obs_req, 1);
    instr = {opc, opr};
    valid = 1'b1;
    az = a;
    e.s = s;
    e.opr = opr;
    e.pc = pcn;
    q.push_back(e);
    @(negedge clock);
    valid = 1'b0;
    e = q.pop_front();
    chk("exec_req", obs_req, 0);
    chk("exec_strobes", obs_s, e.s);
    chk("exec_operand", obs_opr, e.opr);
    @(negedge clock);
    chk("pc_next", obs_pc, e.pc);
  endtask

  initial begin
    rst0 = 1; rst1 = 1; valid = 0; az = 0; sel = 0; instr = '0;
    repeat (2) @(negedge clock);
    chk("rst_pc", obs_pc, 0);
    chk("rst_req", obs_req, 1);
    chk("rst_halt", obs_halt, 0);
    chk("rst_opr", obs_opr, 0);
    chk("rst_strobes", obs_s, 0);
    rst0 = 0;
    do_instr(5'd3, 11'd5, 0, 7'b01_0_1_0_0_0, 11'd1);
    do_instr(5'd5, 11'd3, 0, 7'b10_1_1_0_0_0, 11'd2);
    repeat (4) begin
      @(negedge clock);
      chk("wait_req", obs_req, 1);
      chk("wait_pc", obs_pc, 2);
      chk("wait_strobes", obs_s, 0);
    end
    do_instr(5'd1, 11'd7, 0, 7'b00_0_0_0_1_0, 11'd3);
    do_instr(5'd0, 11'h123, 0, 7'b0, 11'd3);
    chk("halted", obs_halt, 1);
    instr = {5'd3, 11'h555};
    valid = 1;
    repeat (3) begin
      @(negedge clock);
      chk("halt_stay", obs_halt, 1);
      chk("halt_req", obs_req, 0);
      chk("halt_pc", obs_pc, 3);
      chk("halt_opr", obs_opr, 11'h123);
      chk("halt_strobes", obs_s, 0);
    end
    valid = 0;
    rst0 = 1;
    @(negedge clock);
    rst0 = 0;
    chk("rst_halt_exit", obs_halt, 0);
    chk("rst_halt_pc", obs_pc, 0);
    chk("rst_halt_req", obs_req, 1);
    do_instr(5'd9, 11'h40, 1, 7'b0, 11'h40);
    do_instr(5'd9, 11'h40, 0, 7'b0, 11'h41);
    do_instr(5'd10, 11'h40, 1, 7'b0, 11'h42);
    do_instr(5'd10, 11'h40, 0, 7'b0, 11'h40);
    do_instr(5'd2, 11'd9, 0, 7'b00_0_1_0_0_1, 11'h41);
    do_instr(5'd4, 11'd9, 0, 7'b10_0_1_0_0_1, 11'h42);
    do_instr(5'd6, 11'd9, 0, 7'b10_0_1_1_0_1, 11'h43);
    do_instr(5'd7, 11'd2, 0, 7'b10_1_1_1_0_0, 11'h44);
    do_instr(5'd11, 11'd2, 0, 7'b0, 11'h45);
    instr = {5'd1, 11'd7};
    valid = 1;
    @(negedge clock);
    valid = 0;
    chk("sto_wrram", obs_s, 7'b00_0_0_0_1_0);
    rst0 = 1;
    @(negedge clock);
    chk("rst_exec_strobes", obs_s, 0);
    chk("rst_exec_pc", obs_pc, 0);
    chk("rst_exec_req", obs_req, 1);
    sel = 1;
    rst1 = 1;
    @(negedge clock);
    rst1 = 0;
    chk("w4_rst_pc", obs_pc, 0);
    do_instr(5'd8, 11'd15, 0, 7'b0, 11'd15);
    do_instr(5'd31, 11'h2AA, 0, 7'b0, 11'd0);
    do_instr(5'd8, 11'h7F3, 0, 7'b0, 11'd3);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
